// File: rtl/aug_sched_pkg.sv
// Shared types and slot-base helper for the augmentation slot scheduler.
package aug_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY
    } stage_state_t;

    typedef logic slot_sel_t;

    // Wide enough for any BRAM address width; callers cast down to their width.
    typedef logic [31:0] addr_word_t;

    function automatic addr_word_t slot_base(
        input slot_sel_t  sel,
        input addr_word_t base1,
        input addr_word_t base2
    );
        return sel ? base2 : base1;
    endfunction

endpackage

// File: rtl/stage_sequencer.sv
// Launch/busy sequencer for one downstream stage: one-cycle start pulse,
// then waits for the stage's done pulse.
module stage_sequencer
    import aug_sched_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ready,
    input  logic done,
    output logic start,
    output logic busy,
    output logic advance,
    output logic error
);

    stage_state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            start <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready) begin
                        state <= LAUNCH;
                        start <= 1'b1;
                    end
                end
                LAUNCH:  state <= BUSY;
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == BUSY);
    assign advance = done && busy;
    // Any done outside BUSY is a protocol violation by the stage.
    assign error   = done && !busy;

endmodule

// File: rtl/augment_scheduler.sv
// Two-slot ping-pong scheduler for the blur -> rotation -> crop augmentation
// pipeline: tracks slot occupancy, launches stages and stalls the reader.
module augment_scheduler
    import aug_sched_pkg::*;
#(
    parameter int                        ADDR_WIDTH_INT = 11,
    parameter logic [ADDR_WIDTH_INT-1:0] BRAM_INT_BASE1 = 11'h000,
    parameter logic [ADDR_WIDTH_INT-1:0] BRAM_INT_BASE2 = 11'h310,
    parameter int                        CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      blur_done,
    input  logic                      rot_done,
    input  logic                      crop_done,
    output logic [ADDR_WIDTH_INT-1:0] blur_wr_base,
    output logic                      rot_start,
    output logic [ADDR_WIDTH_INT-1:0] rot_rd_base,
    output logic [ADDR_WIDTH_INT-1:0] rot_wr_base,
    output logic                      crop_start,
    output logic [ADDR_WIDTH_INT-1:0] crop_rd_base,
    output logic                      stall,
    output logic [CNT_WIDTH-1:0]      images_out,
    output logic                      seq_error
);

    localparam addr_word_t BASE1_W = addr_word_t'(BRAM_INT_BASE1);
    localparam addr_word_t BASE2_W = addr_word_t'(BRAM_INT_BASE2);

    logic [1:0] blur_full, blur_full_nxt;
    logic [1:0] rot_full, rot_full_nxt;
    slot_sel_t  blur_wr_sel, rot_rd_sel, rot_wr_sel, crop_rd_sel;

    logic rot_ready, rot_busy, rot_adv, rot_err;
    logic crop_ready, crop_busy, crop_adv, crop_err;
    logic blur_accept, blur_reject;
    logic unused_busy;

    assign stall       = blur_full[blur_wr_sel];
    assign blur_accept = blur_done && !stall;
    assign blur_reject = blur_done && stall;

    assign rot_ready  = blur_full[rot_rd_sel] && !rot_full[rot_wr_sel];
    assign crop_ready = rot_full[crop_rd_sel];

    stage_sequencer u_rot_seq (
        .clk     (clk),
        .reset   (reset),
        .ready   (rot_ready),
        .done    (rot_done),
        .start   (rot_start),
        .busy    (rot_busy),
        .advance (rot_adv),
        .error   (rot_err)
    );

    stage_sequencer u_crop_seq (
        .clk     (clk),
        .reset   (reset),
        .ready   (crop_ready),
        .done    (crop_done),
        .start   (crop_start),
        .busy    (crop_busy),
        .advance (crop_adv),
        .error   (crop_err)
    );

    assign unused_busy = rot_busy ^ crop_busy;

    // Clears are applied before sets so a same-bit collision resolves to set.
    always_comb begin
        blur_full_nxt = blur_full;
        rot_full_nxt  = rot_full;
        if (rot_adv) begin
            blur_full_nxt[rot_rd_sel] = 1'b0;
        end
        if (blur_accept) begin
            blur_full_nxt[blur_wr_sel] = 1'b1;
        end
        if (crop_adv) begin
            rot_full_nxt[crop_rd_sel] = 1'b0;
        end
        if (rot_adv) begin
            rot_full_nxt[rot_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blur_full   <= 2'b00;
            rot_full    <= 2'b00;
            blur_wr_sel <= 1'b0;
            rot_rd_sel  <= 1'b0;
            rot_wr_sel  <= 1'b0;
            crop_rd_sel <= 1'b0;
            images_out  <= '0;
            seq_error   <= 1'b0;
        end else begin
            blur_full <= blur_full_nxt;
            rot_full  <= rot_full_nxt;
            if (blur_accept) begin
                blur_wr_sel <= ~blur_wr_sel;
            end
            if (rot_adv) begin
                rot_rd_sel <= ~rot_rd_sel;
                rot_wr_sel <= ~rot_wr_sel;
            end
            if (crop_adv) begin
                crop_rd_sel <= ~crop_rd_sel;
                images_out  <= images_out + 1'b1;
            end
            if (blur_reject || rot_err || crop_err) begin
                seq_error <= 1'b1;
            end
        end
    end

    assign blur_wr_base = ADDR_WIDTH_INT'(slot_base(blur_wr_sel, BASE1_W, BASE2_W));
    assign rot_rd_base  = ADDR_WIDTH_INT'(slot_base(rot_rd_sel,  BASE1_W, BASE2_W));
    assign rot_wr_base  = ADDR_WIDTH_INT'(slot_base(rot_wr_sel,  BASE1_W, BASE2_W));
    assign crop_rd_base = ADDR_WIDTH_INT'(slot_base(crop_rd_sel, BASE1_W, BASE2_W));

endmodule

// File: tb/tb_augment_scheduler.sv
// Directed bench for augment_scheduler: latency, backpressure, ping-pong,
// simultaneous done pulses, spurious done and mid-image reset.
module tb_augment_scheduler;

    logic        clk;
    logic        reset;
    logic        blur_done;
    logic        rot_done;
    logic        crop_done;
    logic [10:0] blur_wr_base;
    logic        rot_start;
    logic [10:0] rot_rd_base;
    logic [10:0] rot_wr_base;
    logic        crop_start;
    logic [10:0] crop_rd_base;
    logic        stall;
    logic [15:0] images_out;
    logic        seq_error;

    int checks;
    int failures;
    logic mon_en;
    logic stall_seen;
    logic [31:0] exp_base;

    augment_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .blur_done    (blur_done),
        .rot_done     (rot_done),
        .crop_done    (crop_done),
        .blur_wr_base (blur_wr_base),
        .rot_start    (rot_start),
        .rot_rd_base  (rot_rd_base),
        .rot_wr_base  (rot_wr_base),
        .crop_start   (crop_start),
        .crop_rd_base (crop_rd_base),
        .stall        (stall),
        .images_out   (images_out),
        .seq_error    (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && stall) stall_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        mon_en     = 1'b0;
        stall_seen = 1'b0;
        reset      = 1'b1;
        blur_done  = 1'b0;
        rot_done   = 1'b0;
        crop_done  = 1'b0;

        // Reset state
        step();
        step();
        check("rst_stall",      stall,        0);
        check("rst_blur_base",  blur_wr_base, 0);
        check("rst_rot_rd",     rot_rd_base,  0);
        check("rst_rot_wr",     rot_wr_base,  0);
        check("rst_crop_rd",    crop_rd_base, 0);
        check("rst_rot_start",  rot_start,    0);
        check("rst_crop_start", crop_start,   0);
        check("rst_images",     images_out,   0);
        check("rst_seq_error",  seq_error,    0);
        reset = 1'b0;
        step();

        // Single image
        mon_en = 1'b1;
        blur_done = 1'b1;
        step();
        blur_done = 1'b0;
        check("s1_rot_start_early", rot_start,    0);
        check("s1_blur_base",       blur_wr_base, 32'h310);
        step();
        check("s1_rot_start",   rot_start,   1);
        check("s1_rot_rd_base", rot_rd_base, 32'h000);
        check("s1_rot_wr_base", rot_wr_base, 32'h000);
        step();
        check("s1_rot_start_pulse", rot_start, 0);
        for (int i = 0; i < 3; i++) step();
        rot_done = 1'b1;
        step();
        rot_done = 1'b0;
        check("s1_crop_start_early", crop_start,  0);
        check("s1_rot_rd_toggle",    rot_rd_base, 32'h310);
        step();
        check("s1_crop_start",   crop_start,   1);
        check("s1_crop_rd_base", crop_rd_base, 32'h000);
        step();
        check("s1_crop_start_pulse", crop_start, 0);
        for (int i = 0; i < 3; i++) step();
        crop_done = 1'b1;
        step();
        crop_done = 1'b0;
        check("s1_images",     images_out,   1);
        check("s1_crop_rd",    crop_rd_base, 32'h310);
        check("s1_seq_error",  seq_error,    0);
        mon_en = 1'b0;
        check("s1_stall_never", stall_seen, 0);

        // Backpressure
        do_reset();
        blur_done = 1'b1;
        step();
        blur_done = 1'b0;
        check("bp_stall_first", stall, 0);
        step();
        check("bp_rot_start", rot_start, 1);
        blur_done = 1'b1;
        step();
        blur_done = 1'b0;
        check("bp_stall_second", stall, 1);
        step();
        step();
        check("bp_stall_hold", stall, 1);
        rot_done = 1'b1;
        step();
        rot_done = 1'b0;
        check("bp_stall_release", stall,        0);
        check("bp_blur_base",     blur_wr_base, 32'h000);
        check("bp_rot_wr_base",   rot_wr_base,  32'h310);
        step();
        check("bp_rot_relaunch",  rot_start,    1);
        check("bp_rot_rd_base",   rot_rd_base,  32'h310);
        check("bp_crop_launch",   crop_start,   1);
        check("bp_crop_rd_base",  crop_rd_base, 32'h000);

        // Ping-pong over four images
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_base = (i % 2 == 1) ? 32'h310 : 32'h000;
            check("pp_blur_base", blur_wr_base, exp_base);
            blur_done = 1'b1;
            step();
            blur_done = 1'b0;
            step();
            check("pp_rot_start",   rot_start,   1);
            check("pp_rot_rd_base", rot_rd_base, exp_base);
            check("pp_rot_wr_base", rot_wr_base, exp_base);
            step();
            rot_done = 1'b1;
            step();
            rot_done = 1'b0;
            step();
            check("pp_crop_start",   crop_start,   1);
            check("pp_crop_rd_base", crop_rd_base, exp_base);
            step();
            crop_done = 1'b1;
            step();
            crop_done = 1'b0;
        end
        check("pp_images",    images_out, 4);
        check("pp_seq_error", seq_error,  0);

        // Simultaneous done pulses with all stages busy
        do_reset();
        blur_done = 1'b1;
        step();
        blur_done = 1'b0;
        step();
        step();
        rot_done = 1'b1;
        step();
        rot_done = 1'b0;
        blur_done = 1'b1;
        step();
        blur_done = 1'b0;
        check("sim_crop_start", crop_start, 1);
        step();
        check("sim_rot_start",   rot_start,   1);
        check("sim_rot_rd_base", rot_rd_base, 32'h310);
        step();
        blur_done = 1'b1;
        rot_done  = 1'b1;
        crop_done = 1'b1;
        step();
        blur_done = 1'b0;
        rot_done  = 1'b0;
        crop_done = 1'b0;
        check("sim_images",    images_out,   1);
        check("sim_stall",     stall,        0);
        check("sim_blur_base", blur_wr_base, 32'h310);
        check("sim_rot_rd",    rot_rd_base,  32'h000);
        check("sim_rot_wr",    rot_wr_base,  32'h000);
        check("sim_crop_rd",   crop_rd_base, 32'h310);
        check("sim_seq_error", seq_error,    0);
        step();
        check("sim_rot_relaunch",  rot_start,  1);
        check("sim_crop_relaunch", crop_start, 1);

        // Spurious crop_done while crop is idle
        do_reset();
        crop_done = 1'b1;
        step();
        crop_done = 1'b0;
        check("sp_seq_error", seq_error,  1);
        check("sp_images",    images_out, 0);
        for (int i = 0; i < 3; i++) step();
        check("sp_seq_sticky", seq_error, 1);

        // Reset mid-rotation with both blur slots full
        do_reset();
        blur_done = 1'b1;
        step();
        blur_done = 1'b0;
        step();
        blur_done = 1'b1;
        step();
        blur_done = 1'b0;
        step();
        check("mr_stall_before", stall, 1);
        reset = 1'b1;
        #1;
        check("mr_stall",      stall,        0);
        check("mr_blur_base",  blur_wr_base, 0);
        check("mr_rot_rd",     rot_rd_base,  0);
        check("mr_rot_wr",     rot_wr_base,  0);
        check("mr_crop_rd",    crop_rd_base, 0);
        check("mr_rot_start",  rot_start,    0);
        check("mr_images",     images_out,   0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mr_no_rot_start",  rot_start,  0);
            check("mr_no_crop_start", crop_start, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
